alu_instr_encoder: RTL and testbench

Encoder and issue buffer that drives the ALU's instruction port. It accepts compact operation requests (mnemonic, register numbers, shift amount, immediate, operand values) over a valid/ready handshake, encodes each into a 32-bit MIPS R- or I-type word, and queues it with its two operand values in a FIFO. The FIFO presents `i_datain`, `gr1` and `gr2` to the ALU stage over a second valid/ready handshake.

---
 rtl/alu_instr_encoder_if.sv | 48 ++++
 rtl/alu_instr_encoder.sv | 169 ++++++++++++++++
 tb/tb_alu_instr_encoder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_instr_encoder_if.sv
// ---------------------------------------------------------------------------
// alu_instr_encoder_if
// Bundles the request handshake, the issue (ALU-side) handshake and the
// status outputs of alu_instr_encoder.
//   master : request producer / ALU consumer side (drives req_*, out_ready)
//   slave  : the encoder itself (drives req_ready, out_*, i_datain, gr1/gr2,
//            err_illegal, illegal_cnt, level)
// ---------------------------------------------------------------------------
interface alu_instr_encoder_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_mnem;
    logic [4:0]    req_rs;
    logic [4:0]    req_rt;
    logic [4:0]    req_rd;
    logic [4:0]    req_shamt;
    logic [15:0]   req_imm;
    logic [31:0]   req_a;
    logic [31:0]   req_b;

    logic          out_valid;
    logic          out_ready;
    logic [31:0]   i_datain;
    logic [31:0]   gr1;
    logic [31:0]   gr2;

    logic          err_illegal;
    logic [7:0]    illegal_cnt;
    logic [LW-1:0] level;

    modport master (
        output req_valid, req_mnem, req_rs, req_rt, req_rd, req_shamt,
               req_imm, req_a, req_b, out_ready,
        input  req_ready, out_valid, i_datain, gr1, gr2, err_illegal,
               illegal_cnt, level
    );

    modport slave (
        input  req_valid, req_mnem, req_rs, req_rt, req_rd, req_shamt,
               req_imm, req_a, req_b, out_ready,
        output req_ready, out_valid, i_datain, gr1, gr2, err_illegal,
               illegal_cnt, level
    );
endinterface

// File: rtl/alu_instr_encoder.sv
// ---------------------------------------------------------------------------
// alu_instr_encoder
// Encodes compact operation requests into 32-bit MIPS R-/I-type words and
// queues them, together with their operand values, in a DEPTH-entry FIFO that
// feeds the ALU instruction port.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_instr_encoder_if.slave (request handshake, issue handshake,
//            err_illegal pulse, saturating illegal_cnt, FIFO level)
// ---------------------------------------------------------------------------
module alu_instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_instr_encoder_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [31:0]   mem_word_q [DEPTH];
    logic [31:0]   mem_a_q    [DEPTH];
    logic [31:0]   mem_b_q    [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          err_illegal_q, err_illegal_d;
    logic [7:0]    illegal_cnt_q, illegal_cnt_d;

    logic          legal;
    logic          r_type;
    logic [5:0]    funct;
    logic [5:0]    opcode;
    logic [4:0]    enc_rs;
    logic [4:0]    enc_rd;
    logic [4:0]    enc_shamt;
    logic [31:0]   enc_word;

    logic          req_ready;
    logic          out_valid;
    logic          accept;
    logic          push;
    logic          pop;

    // ---- instruction encoding (combinational at the write port) ----
    always_comb begin
        legal     = 1'b1;
        r_type    = 1'b1;
        funct     = 6'h00;
        opcode    = 6'h00;
        enc_rs    = bus.req_rs;
        enc_rd    = bus.req_rd;
        enc_shamt = bus.req_shamt;
        case (bus.req_mnem)
            5'd0:    funct = 6'h20;
            5'd1:    funct = 6'h21;
            5'd2:    funct = 6'h22;
            5'd3:    funct = 6'h23;
            5'd4:    funct = 6'h24;
            5'd5:    funct = 6'h25;
            5'd6:    funct = 6'h26;
            5'd7:    funct = 6'h27;
            5'd8:    funct = 6'h2A;
            5'd9:    funct = 6'h2B;
            5'd10:   funct = 6'h00;
            5'd11:   funct = 6'h02;
            5'd12:   funct = 6'h03;
            5'd13:   funct = 6'h18;
            5'd14:   funct = 6'h1A;
            5'd15:   begin r_type = 1'b0; opcode = 6'h08; end
            5'd16:   begin r_type = 1'b0; opcode = 6'h0C; end
            5'd17:   begin r_type = 1'b0; opcode = 6'h0D; end
            5'd18:   begin r_type = 1'b0; opcode = 6'h0E; end
            5'd19:   begin r_type = 1'b0; opcode = 6'h0A; end
            5'd20:   begin r_type = 1'b0; opcode = 6'h0B; end
            5'd21:   begin r_type = 1'b0; opcode = 6'h04; end
            5'd22:   begin r_type = 1'b0; opcode = 6'h05; end
            default: begin legal = 1'b0; r_type = 1'b0; end
        endcase

        // shifts take their amount from shamt and have no rs source;
        // every other R-type op has shamt zero
        if (bus.req_mnem >= 5'd10 && bus.req_mnem <= 5'd12) begin
            enc_rs = 5'd0;
        end else begin
            enc_shamt = 5'd0;
        end
        // MULT/DIV write HI/LO, so rd is meaningless
        if (bus.req_mnem == 5'd13 || bus.req_mnem == 5'd14) begin
            enc_rd = 5'd0;
        end

        if (r_type) begin
            enc_word = {6'h00, enc_rs, bus.req_rt, enc_rd, enc_shamt, funct};
        end else begin
            enc_word = {opcode, bus.req_rs, bus.req_rt, bus.req_imm};
        end
    end

    // ---- handshakes and next state ----
    // req_ready depends on level only: no pass-through when full
    assign req_ready = (level_q < DEPTH_L);
    assign out_valid = (level_q != '0);
    assign accept    = bus.req_valid && req_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        err_illegal_d = accept && !legal;
        illegal_cnt_d = illegal_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
        if (accept && !legal && illegal_cnt_q != 8'hFF) begin
            illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            err_illegal_q <= 1'b0;
            illegal_cnt_q <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_word_q[i] <= 32'd0;
                mem_a_q[i]    <= 32'd0;
                mem_b_q[i]    <= 32'd0;
            end
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            err_illegal_q <= err_illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
            if (push) begin
                mem_word_q[wr_ptr_q] <= enc_word;
                mem_a_q[wr_ptr_q]    <= bus.req_a;
                mem_b_q[wr_ptr_q]    <= bus.req_b;
            end
        end
    end

    // ---- outputs ----
    assign bus.req_ready   = req_ready;
    assign bus.out_valid   = out_valid;
    assign bus.i_datain    = mem_word_q[rd_ptr_q];
    assign bus.gr1         = mem_a_q[rd_ptr_q];
    assign bus.gr2         = mem_b_q[rd_ptr_q];
    assign bus.err_illegal = err_illegal_q;
    assign bus.illegal_cnt = illegal_cnt_q;
    assign bus.level       = level_q;

endmodule

// File: tb/tb_alu_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_alu_instr_encoder
// Self-checking bench for alu_instr_encoder: directed vector table, hand
// sequences for full/illegal/reset corners, and random traffic against a
// queue-based reference model.
// ---------------------------------------------------------------------------
module tb_alu_instr_encoder;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    alu_instr_encoder_if #(.DEPTH(DEPTH)) bus ();

    alu_instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---- reference model ----
    localparam int FUNCT_TAB [15] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 24, 26};
    localparam int OPC_TAB   [8]  = '{8, 12, 13, 14, 10, 11, 4, 5};

    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t m_q[$];
    int   m_cnt;
    bit   m_err;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] ref_enc(int mnem, int rs, int rt, int rd, int sh, int imm);
        int v;
        if (mnem < 15) begin
            if (mnem >= 10 && mnem <= 12) rs = 0;
            else sh = 0;
            if (mnem == 13 || mnem == 14) rd = 0;
            v = rs * (2 ** 21) + rt * (2 ** 16) + rd * (2 ** 11) + sh * 64 + FUNCT_TAB[mnem];
        end else begin
            v = OPC_TAB[mnem - 15] * (2 ** 26) + rs * (2 ** 21) + rt * (2 ** 16) + imm;
        end
        return 32'(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_state();
        chk("level", 32'(bus.level), 32'(m_q.size()));
        chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
        chk("req_ready", 32'(bus.req_ready), 32'(m_q.size() < DEPTH));
        chk("err_illegal", 32'(bus.err_illegal), 32'(m_err));
        chk("illegal_cnt", 32'(bus.illegal_cnt), 32'(m_cnt));
        if (m_q.size() != 0) begin
            chk("i_datain", bus.i_datain, m_q[0].w);
            chk("gr1", bus.gr1, m_q[0].a);
            chk("gr2", bus.gr2, m_q[0].b);
        end
    endtask

    // One clock: drive inputs, advance model with pre-edge state, check after edge.
    task automatic step(input bit v, input int mnem, input int rs, input int rt, input int rd,
                        input int sh, input int imm, input logic [31:0] a, input logic [31:0] b,
                        input bit ordy);
        bit   acc, pp;
        ent_t e;
        bus.req_valid = v;
        bus.req_mnem  = 5'(mnem);
        bus.req_rs    = 5'(rs);
        bus.req_rt    = 5'(rt);
        bus.req_rd    = 5'(rd);
        bus.req_shamt = 5'(sh);
        bus.req_imm   = 16'(imm);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.out_ready = ordy;
        acc = v && (m_q.size() < DEPTH);
        pp  = ordy && (m_q.size() != 0);
        @(posedge clk);
        #1;
        if (pp) void'(m_q.pop_front());
        m_err = 0;
        if (acc) begin
            if (mnem < 23) begin
                e.w = ref_enc(mnem, rs, rt, rd, sh, imm);
                e.a = a;
                e.b = b;
                m_q.push_back(e);
            end else begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        check_state();
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, ordy);
    endtask

    task automatic rand_push(input bit ordy);
        step(1, $urandom_range(22, 0), $urandom_range(31, 0), $urandom_range(31, 0),
             $urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(65535, 0),
             $urandom, $urandom, ordy);
    endtask

    typedef struct {
        int          mnem;
        int          rs;
        int          rt;
        int          rd;
        int          sh;
        int          imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{10, 7, 1, 2, 1, 0, 32'h1111_1111, 32'hDDDD_DDDD, 32'h0001_1040};  // SLL
        vecs[1] = '{2, 0, 1, 16, 5, 0, 32'd1, 32'd3, 32'h0001_8022};                   // SUB
        vecs[2] = '{15, 3, 4, 7, 7, 16'hFFFF, 32'hA, 32'hB, 32'h2064_FFFF};            // ADDI
        vecs[3] = '{13, 1, 2, 9, 3, 0, 32'h5, 32'h6, 32'h0022_0018};                   // MULT
        vecs[4] = '{12, 31, 5, 6, 31, 0, 32'h8000_0000, 32'h7, 32'h0005_37C3};         // SRA
        vecs[5] = '{22, 1, 2, 9, 9, 16'h1234, 32'hFFFF_FFFF, 32'h0, 32'h1422_1234};    // BNE
        vecs[6] = '{14, 31, 31, 31, 31, 0, 32'h1, 32'h2, 32'h03FF_001A};               // DIV
        vecs[7] = '{7, 2, 3, 4, 7, 0, 32'h3, 32'h4, 32'h0043_2027};                    // NOR

        m_cnt = 0;
        m_err = 0;
        rst_n = 1'b0;
        bus.req_valid = 0; bus.req_mnem = 0; bus.req_rs = 0; bus.req_rt = 0;
        bus.req_rd = 0; bus.req_shamt = 0; bus.req_imm = 0; bus.req_a = 0;
        bus.req_b = 0; bus.out_ready = 0;
        #12;
        check_state();
        chk("reset_i_datain", bus.i_datain, 32'd0);
        chk("reset_gr1", bus.gr1, 32'd0);
        chk("reset_gr2", bus.gr2, 32'd0);
        rst_n = 1'b1;

        // directed encodings: push into empty FIFO, visible the next cycle
        for (int i = 0; i < 8; i++) begin
            step(1, vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
                 vecs[i].imm, vecs[i].a, vecs[i].b, 0);
            chk("vec_valid", 32'(bus.out_valid), 32'd1);
            chk("vec_word", bus.i_datain, vecs[i].exp_word);
            chk("vec_gr1", bus.gr1, vecs[i].a);
            chk("vec_gr2", bus.gr2, vecs[i].b);
            idle(1);
        end

        // full FIFO: 5 pushes with no pops, only 4 land
        for (int i = 0; i < 5; i++) rand_push(0);
        chk("full_level", 32'(bus.level), 32'd4);
        chk("full_ready", 32'(bus.req_ready), 32'd0);
        rand_push(1);   // pop while full: request must still be refused
        chk("full_pop_level", 32'(bus.level), 32'd3);
        for (int i = 0; i < 3; i++) idle(1);
        chk("drained", 32'(bus.out_valid), 32'd0);

        // steady-state push+pop at level 2, pointers wrap
        rand_push(0);
        rand_push(0);
        for (int i = 0; i < 10; i++) begin
            rand_push(1);
            chk("steady_level", 32'(bus.level), 32'd2);
        end
        idle(1);
        idle(1);

        // single illegal request
        step(1, 23, 1, 2, 3, 4, 5, 32'h1, 32'h2, 0);
        chk("ill_pulse", 32'(bus.err_illegal), 32'd1);
        chk("ill_cnt1", 32'(bus.illegal_cnt), 32'd1);
        chk("ill_level", 32'(bus.level), 32'd0);
        idle(0);
        chk("ill_pulse_end", 32'(bus.err_illegal), 32'd0);

        // illegal alongside a pop
        rand_push(0);
        rand_push(0);
        step(1, 31, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
        chk("ill_pop_level", 32'(bus.level), 32'd1);
        idle(1);

        // saturation
        for (int i = 0; i < 300; i++)
            step(1, $urandom_range(31, 23), 0, 0, 0, 0, 0, $urandom, $urandom, 1);
        chk("ill_sat", 32'(bus.illegal_cnt), 32'd255);
        idle(1);

        // reset mid-operation with 3 entries queued
        for (int i = 0; i < 3; i++) rand_push(0);
        #2;
        rst_n = 1'b0;
        #1;
        m_q.delete();
        m_cnt = 0;
        m_err = 0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_cnt", 32'(bus.illegal_cnt), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1, 0, 1, 2, 3, 4, 0, 32'hCAFE_0001, 32'hCAFE_0002, 0);
        chk("post_rst_level", 32'(bus.level), 32'd1);
        chk("post_rst_word", bus.i_datain, 32'h0022_1820);
        idle(1);
        chk("post_rst_alone", 32'(bus.out_valid), 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3, 0) != 0)
                step(1, $urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(31, 0),
                     $urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(65535, 0),
                     $urandom, $urandom, 1'($urandom_range(1, 0)));
            else
                idle(1'($urandom_range(1, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
